id_redirect_unit: RTL

ID_REDIRECT_UNIT -- requirements
Module: id_redirect_unit

---
 rtl/id_redirect_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/id_redirect_unit.sv
// IF/ID pipeline register with ID-stage branch/jump resolution and operand-hazard stall control.
// Define DELAY_SLOT_EN to keep the word after a taken branch (MIPS delay slot) instead of squashing it.
module id_redirect_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_plus_4,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dst,
    output logic [31:0] branch,
    output logic        select_pc,
    output logic        pc_hold,
    output logic        id_bubble,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc_plus_4,
    output logic        id_valid
);

    localparam logic [5:0] OpJ   = 6'h02;
    localparam logic [5:0] OpJal = 6'h03;
    localparam logic [5:0] OpBeq = 6'h04;
    localparam logic [5:0] OpBne = 6'h05;

    typedef enum logic [0:0] {StRun, StHold} state_e;

    state_e      state_q;
    logic        cnt_q;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [5:0]  opcode;
    logic [4:0]  rs_field, rt_field;
    logic [15:0] imm16;
    logic        is_beq, is_bne, is_cond, is_jump;
    logic        operands_equal, taken;
    logic [31:0] cond_target, jump_target, target;
    logic        src_match, hazard, flush;
    logic [1:0]  stall_len;

    assign opcode   = instr_q[31:26];
    assign rs_field = instr_q[25:21];
    assign rt_field = instr_q[20:16];
    assign imm16    = instr_q[15:0];

    assign is_beq  = (opcode == OpBeq);
    assign is_bne  = (opcode == OpBne);
    assign is_cond = is_beq | is_bne;
    assign is_jump = (opcode == OpJ) | (opcode == OpJal);

    assign operands_equal = (rs_data == rt_data);
    assign taken = (is_beq & operands_equal) | (is_bne & ~operands_equal) | is_jump;

    assign cond_target = pc4_q + {{14{imm16[15]}}, imm16, 2'b00};
    assign jump_target = {pc4_q[31:28], instr_q[25:0], 2'b00};
    assign target      = is_jump ? jump_target : cond_target;

    // Branches compare in ID, so they must wait even for ALU results; others only for loads.
    always_comb begin
        stall_len = 2'd0;
        if (is_cond) begin
            if (ex_mem_read) begin
                stall_len = 2'd2;
            end else if (ex_reg_write) begin
                stall_len = 2'd1;
            end
        end else if (!is_jump && ex_mem_read) begin
            stall_len = 2'd1;
        end
    end

    assign src_match = (ex_dst != 5'd0) & ((ex_dst == rs_field) | (ex_dst == rt_field));
    assign hazard    = (state_q == StRun) & valid_q & src_match & (stall_len != 2'd0);

    assign pc_hold   = (state_q == StHold) | hazard;
    assign id_bubble = pc_hold;
    assign select_pc = valid_q & taken & ~pc_hold;
    assign branch    = select_pc ? target : 32'h0;

`ifdef DELAY_SLOT_EN
    assign flush = 1'b0;
`else
    assign flush = select_pc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hazard && stall_len == 2'd2) begin
                        state_q <= StHold;
                        cnt_q   <= 1'b0;
                    end
                end
                StHold: begin
                    if (cnt_q == 1'b0) begin
                        state_q <= StRun;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (!pc_hold) begin
            pc4_d = pc_plus_4;
            if (flush) begin
                instr_d = 32'h0;
                valid_d = 1'b0;
            end else begin
                instr_d = instruction;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign id_instruction = instr_q;
    assign id_pc_plus_4   = pc4_q;
    assign id_valid       = valid_q;

endmodule
